// File: rtl/bus_memory.sv
// Memory-side bus responder: latches an address on astb, then serves rd/wr strobes from a word array.
// Optional address range checking is enabled by defining BUS_MEMORY_ADDR_CHECK_EN.
module bus_memory #(
   parameter int DW        = 64,
   parameter int AW        = 20,
   parameter int MEM_WORDS = 32768
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          astb,
   input  logic          rd,
   input  logic          wr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          doe,
   output logic          err
);

   localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RDATA = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          doe_q, doe_d;
   logic          err_q, err_d;

   logic [DW-1:0] mem [MEM_WORDS];
   logic [IW-1:0] mem_idx;
   logic          mem_we;
   logic          addr_ok;

   assign mem_idx = addr_q[IW-1:0];

`ifdef BUS_MEMORY_ADDR_CHECK_EN
   assign addr_ok = ({{(32-AW){1'b0}}, addr_q} < 32'(MEM_WORDS));
`else
   // Without checking, upper address bits simply alias onto the array.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_q;
   assign addr_ok          = 1'b1;
`endif

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      doe_d   = doe_q;
      err_d   = 1'b0;
      mem_we  = 1'b0;

      if (astb) begin
         addr_d  = din[AW-1:0];
         state_d = ST_ARMED;
         doe_d   = 1'b0;
      end else if (rd && wr) begin
         err_d = 1'b1;
      end else if (state_q == ST_IDLE) begin
         err_d = rd | wr;
      end else if (!(state_q == ST_RDATA && rd)) begin
         // ARMED, or the first cycle of RDATA with rd dropped (then treated as ARMED).
         state_d = ST_ARMED;
         doe_d   = 1'b0;
         if (rd) begin
            state_d = ST_RDATA;
            doe_d   = 1'b1;
            dout_d  = addr_ok ? mem[mem_idx] : '0;
            err_d   = !addr_ok;
         end else if (wr) begin
            mem_we = addr_ok;
            err_d  = !addr_ok;
         end
      end

      if (reset) begin
         mem_we = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         dout_q  <= '0;
         doe_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         doe_q   <= doe_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the array is deliberately not reset; contents survive reset and map onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= din;
      end
   end

   assign dout = dout_q;
   assign doe  = doe_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bus_memory.sv
// Self-checking bench for bus_memory: directed vector table, reset/aliasing sequences,
// and randomized traffic checked against a behavioural memory model.
module tb_bus_memory;

   localparam int DW    = 64;
   localparam int AW    = 20;
   localparam int WORDS = 32768;
`ifdef BUS_MEMORY_ADDR_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, astb, rd, wr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          doe, err;

   int total = 0;
   int bad   = 0;

   bus_memory #(.DW(DW), .AW(AW), .MEM_WORDS(WORDS)) dut (
      .clk  (clk),
      .reset(reset),
      .astb (astb),
      .rd   (rd),
      .wr   (wr),
      .din  (din),
      .dout (dout),
      .doe  (doe),
      .err  (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          astb, rd, wr;
      logic [DW-1:0] din;
      logic          exp_doe, exp_err;
      logic [DW-1:0] exp_dout;
   } vec_t;

   vec_t vecs [18];

   // Behavioural model state
   logic [DW-1:0] m_mem [int];
   bit            m_have, m_reading, m_doe, m_err;
   int            m_addr;
   logic [DW-1:0] m_dout;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic a, input logic rr, input logic w,
                        input logic [DW-1:0] d);
      @(negedge clk);
      reset = r; astb = a; rd = rr; wr = w; din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic e_doe, input logic e_err,
                            input logic [DW-1:0] e_dout);
      check({name, ".doe"}, {63'd0, doe}, {63'd0, e_doe});
      check({name, ".err"}, {63'd0, err}, {63'd0, e_err});
      check({name, ".dout"}, dout, e_dout);
   endtask

   // Model: what the responder should present after one clock with these inputs.
   task automatic model_step(input logic r, input logic a, input logic rr, input logic w,
                             input logic [DW-1:0] d);
      bit in_range;
      m_err = 1'b0;
      if (r) begin
         m_have = 0; m_reading = 0; m_doe = 0; m_dout = '0; m_addr = 0;
         return;
      end
      if (a) begin
         m_addr = int'(d[AW-1:0]);
         m_have = 1; m_reading = 0; m_doe = 0;
      end else if (rr && w) begin
         m_err = 1;
      end else if (!m_have) begin
         m_err = rr | w;
      end else if (m_reading && rr) begin
         m_err = 0;  // read data simply held
      end else begin
         in_range = !CHECK || (m_addr < WORDS);
         if (rr) begin
            m_reading = 1; m_doe = 1;
            m_dout = in_range ? m_mem[m_addr % WORDS] : '0;
            m_err = !in_range;
         end else begin
            m_reading = 0; m_doe = 0;
            if (w) begin
               if (in_range) m_mem[m_addr % WORDS] = d;
               else m_err = 1;
            end
         end
      end
   endtask

   task automatic rcycle(input logic r, input logic a, input logic rr, input logic w,
                         input logic [DW-1:0] d);
      model_step(r, a, rr, w, d);
      drive(r, a, rr, w, d);
      check_out("rand", m_doe, m_err, m_dout);
   endtask

   initial begin
      int idx_set [8];
      logic [DW-1:0] d;
      int sel, k, op;

      reset = 1'b1; astb = 1'b0; rd = 1'b0; wr = 1'b0; din = '0;

      // ------------------------------------------------ directed table
      vecs[0]  = '{1, 0, 0, 64'h100,               0, 0, 64'h0};
      vecs[1]  = '{0, 0, 1, 64'h0123456789ABCDEF, 0, 0, 64'h0};
      vecs[2]  = '{1, 0, 0, 64'h100,               0, 0, 64'h0};
      vecs[3]  = '{0, 1, 0, 64'h0,                 1, 0, 64'h0123456789ABCDEF};
      vecs[4]  = '{0, 1, 0, 64'h0,                 1, 0, 64'h0123456789ABCDEF};
      vecs[5]  = '{0, 0, 0, 64'h0,                 0, 0, 64'h0123456789ABCDEF};
      vecs[6]  = '{0, 1, 1, 64'hFF,                0, 1, 64'h0123456789ABCDEF};
      vecs[7]  = '{0, 1, 0, 64'h0,                 1, 0, 64'h0123456789ABCDEF};
      vecs[8]  = '{0, 0, 1, 64'hA5,                0, 0, 64'h0123456789ABCDEF};
      vecs[9]  = '{0, 1, 0, 64'h0,                 1, 0, 64'hA5};
      vecs[10] = '{1, 1, 1, 64'h200,               0, 0, 64'hA5};
      vecs[11] = '{0, 0, 1, 64'h1111,              0, 0, 64'hA5};
      vecs[12] = '{0, 1, 1, 64'hFF,                0, 1, 64'hA5};
      vecs[13] = '{0, 1, 0, 64'h0,                 1, 0, 64'h1111};
      vecs[14] = '{1, 0, 0, 64'h8100,              0, 0, 64'h1111};
      if (CHECK) begin
         vecs[15] = '{0, 1, 0, 64'h0,              1, 1, 64'h0};
         vecs[16] = '{0, 1, 1, 64'hFF,             1, 1, 64'h0};
         vecs[17] = '{0, 0, 0, 64'h0,              0, 0, 64'h0};
      end else begin
         vecs[15] = '{0, 1, 0, 64'h0,              1, 0, 64'hA5};
         vecs[16] = '{0, 1, 1, 64'hFF,             1, 1, 64'hA5};
         vecs[17] = '{0, 0, 0, 64'h0,              0, 0, 64'hA5};
      end

      drive(1, 0, 0, 0, '0);
      drive(1, 0, 0, 0, '0);
      check_out("reset", 1'b0, 1'b0, 64'h0);

      for (int i = 0; i < 18; i++) begin
         drive(0, vecs[i].astb, vecs[i].rd, vecs[i].wr, vecs[i].din);
         check_out($sformatf("vec%0d", i), vecs[i].exp_doe, vecs[i].exp_err, vecs[i].exp_dout);
      end

      // ------------------------------------------------ rd with no address after reset
      drive(1, 0, 0, 0, '0);
      drive(0, 0, 1, 0, '0);
      check_out("idle_rd", 1'b0, 1'b1, 64'h0);
      drive(0, 0, 0, 0, '0);
      check_out("idle_rd_pulse_end", 1'b0, 1'b0, 64'h0);
      drive(0, 0, 0, 1, 64'h77);
      check_out("idle_wr", 1'b0, 1'b1, 64'h0);

      // ------------------------------------------------ reset during RDATA
      drive(0, 1, 0, 0, 64'h20);
      drive(0, 0, 0, 1, 64'hCAFE);
      drive(0, 0, 1, 0, '0);
      check_out("pre_reset_rd", 1'b1, 1'b0, 64'hCAFE);
      drive(1, 0, 1, 1, 64'hDEAD);
      check_out("reset_mid_read", 1'b0, 1'b0, 64'h0);
      drive(0, 0, 1, 0, '0);
      check_out("rd_after_reset", 1'b0, 1'b1, 64'h0);
      drive(0, 1, 0, 0, 64'h20);
      drive(0, 0, 1, 0, '0);
      check_out("no_commit_on_reset", 1'b1, 1'b0, 64'hCAFE);

      // ------------------------------------------------ out-of-range / aliasing at 0x8000
      drive(0, 1, 0, 0, 64'h0);
      drive(0, 0, 0, 1, 64'h1234);
      drive(0, 1, 0, 0, 64'h8000);
      drive(0, 0, 0, 1, 64'h55);
      check_out("hi_wr", 1'b0, CHECK, 64'hCAFE);
      drive(0, 1, 0, 0, 64'h0);
      drive(0, 0, 1, 0, '0);
      check_out("lo_rd", 1'b1, 1'b0, CHECK ? 64'h1234 : 64'h55);
      drive(0, 1, 0, 0, 64'h8000);
      drive(0, 0, 1, 0, '0);
      check_out("hi_rd", 1'b1, CHECK, CHECK ? 64'h0 : 64'h55);

      // ------------------------------------------------ randomized traffic vs model
      idx_set = '{32'h000, 32'h001, 32'h155, 32'h2AA, 32'h7FFF, 32'h4000, 32'h123, 32'h3FF0};
      rcycle(1, 0, 0, 0, '0);
      for (int i = 0; i < 8; i++) begin
         rcycle(0, 1, 0, 0, 64'(idx_set[i]));
         rcycle(0, 0, 0, 1, {$urandom, $urandom});
      end
      for (int i = 0; i < 1500; i++) begin
         op  = int'($urandom_range(0, 99));
         sel = int'($urandom_range(0, 7));
         k   = int'($urandom_range(0, 3));
         d   = {$urandom, $urandom};
         if (op < 2)       rcycle(1, 0, 1, 1, d);
         else if (op < 22) rcycle(0, 1, op[0], op[1], 64'((k << 15) | idx_set[sel]));
         else if (op < 27) rcycle(0, 0, 1, 1, d);
         else if (op < 57) rcycle(0, 0, 1, 0, d);
         else if (op < 77) rcycle(0, 0, 0, 1, d);
         else              rcycle(0, 0, 0, 0, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
